// File: rtl/alu_operand_stage_if.sv
// Issue/execute bus of the ALU operand stage: upstream instruction handshake
// plus the registered ALU operands handed downstream.
interface alu_operand_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic        out_illegal;
  logic [31:0] out_pc;

  // master: the pipeline around the stage; slave: the stage itself
  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, alu_a, alu_b, alu_op,
           out_rd, out_rd_we, out_illegal, out_pc
  );

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, alu_a, alu_b, alu_op,
           out_rd, out_rd_we, out_illegal, out_pc
  );
endinterface

// File: rtl/alu_operand_stage.sv
// ID/EX stage for RV32I OP/OP-IMM/LUI/AUIPC: decode, immediate generation,
// forwarding and a registered ALU operand slot. ALU_OPERAND_STAGE_PERF_EN adds
// perf_issued/perf_stalls counters.
module alu_operand_stage
`ifdef ALU_OPERAND_STAGE_PERF_EN
#(
  parameter int CNT_W = 32
)
`endif
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  alu_operand_stage_if.slave      bus,
  input  logic [31:0]             rs1_data,
  input  logic [31:0]             rs2_data,
  input  logic                    fwd_valid,
  input  logic [4:0]              fwd_rd,
  input  logic [31:0]             fwd_data
`ifdef ALU_OPERAND_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]        perf_issued,
  output logic [CNT_W-1:0]        perf_stalls
`endif
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SRA = 4'b1101;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Handshake: a transfer happens on a rising edge where in_valid & in_ready;
  // the output slot is consumed on an edge where out_valid & out_ready. The
  // producer holds its payload while valid is high and ready is low.

  logic [31:0] inst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] rs1_val, rs2_val;
  logic [31:0] imm_i, imm_u;

  assign inst   = bus.in_inst;
  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign funct7 = inst[31:25];
  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_u  = {inst[31:12], 12'b0};

  // x0 always reads as zero, even when a write-back to x0 is being forwarded
  assign rs1_val = (rs1 == 5'd0) ? 32'd0 :
                   (fwd_valid && fwd_rd == rs1) ? fwd_data : rs1_data;
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 :
                   (fwd_valid && fwd_rd == rs2) ? fwd_data : rs2_data;

  logic        dec_legal;
  logic [31:0] dec_a, dec_b;
  logic [3:0]  dec_op;
  logic        is_shift;

  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  always_comb begin
    dec_legal = 1'b0;
    dec_a     = 32'd0;
    dec_b     = 32'd0;
    dec_op    = ALU_ADD;
    case (opcode)
      OPC_OP: begin
        dec_a = rs1_val;
        dec_b = is_shift ? {27'b0, rs2_val[4:0]} : rs2_val;
        if (funct7 == F7_BASE) begin
          dec_legal = 1'b1;
          dec_op    = {1'b0, funct3};
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          dec_legal = 1'b1;
          dec_op    = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          dec_legal = 1'b1;
          dec_op    = ALU_SRA;
        end
      end
      OPC_IMM: begin
        dec_a = rs1_val;
        dec_b = is_shift ? {27'b0, inst[24:20]} : imm_i;
        if (funct3 == 3'b001) begin
          dec_legal = (funct7 == F7_BASE);
          dec_op    = {1'b0, funct3};
        end else if (funct3 == 3'b101) begin
          dec_legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          dec_op    = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
        end else begin
          dec_legal = 1'b1;
          dec_op    = {1'b0, funct3};
        end
      end
      OPC_LUI: begin
        dec_legal = 1'b1;
        dec_b     = imm_u;
      end
      OPC_AUIPC: begin
        dec_legal = 1'b1;
        dec_a     = bus.in_pc;
        dec_b     = imm_u;
      end
      default: dec_legal = 1'b0;
    endcase
    // Traps carry no operands so the ALU result stays deterministic
    if (!dec_legal) begin
      dec_a  = 32'd0;
      dec_b  = 32'd0;
      dec_op = ALU_ADD;
    end
  end

  logic        out_valid_q;
  logic [31:0] alu_a_q, alu_b_q, out_pc_q;
  logic [3:0]  alu_op_q;
  logic [4:0]  out_rd_q;
  logic        out_rd_we_q, out_illegal_q;
  logic        in_ready_c, take;

  assign in_ready_c = flush | ~out_valid_q | bus.out_ready;
  assign take       = bus.in_valid & in_ready_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      alu_a_q       <= 32'd0;
      alu_b_q       <= 32'd0;
      alu_op_q      <= 4'd0;
      out_rd_q      <= 5'd0;
      out_rd_we_q   <= 1'b0;
      out_illegal_q <= 1'b0;
      out_pc_q      <= 32'd0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (take) begin
      out_valid_q   <= 1'b1;
      alu_a_q       <= dec_a;
      alu_b_q       <= dec_b;
      alu_op_q      <= dec_op;
      out_rd_q      <= rd;
      out_rd_we_q   <= dec_legal && (rd != 5'd0);
      out_illegal_q <= ~dec_legal;
      out_pc_q      <= bus.in_pc;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.out_valid   = out_valid_q;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_op      = alu_op_q;
  assign bus.out_rd      = out_rd_q;
  assign bus.out_rd_we   = out_rd_we_q;
  assign bus.out_illegal = out_illegal_q;
  assign bus.out_pc      = out_pc_q;

`ifdef ALU_OPERAND_STAGE_PERF_EN
  // Counters survive flush; an input dropped by flush is not an issue
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_issued <= '0;
      perf_stalls <= '0;
    end else begin
      if (take && !flush)
        perf_issued <= perf_issued + 1'b1;
      if (out_valid_q && !bus.out_ready)
        perf_stalls <= perf_stalls + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed scoreboard bench for alu_operand_stage: drivers push hand-computed
// results into exp_q, a monitor pops them as the stage hands operands on.
module tb_alu_operand_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [31:0] rs1_data, rs2_data, fwd_data;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;

  alu_operand_stage_if bus ();

`ifdef ALU_OPERAND_STAGE_PERF_EN
  logic [31:0] perf_issued, perf_stalls;
`endif

  alu_operand_stage dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .bus      (bus),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .fwd_valid(fwd_valid),
    .fwd_rd   (fwd_rd),
    .fwd_data (fwd_data)
`ifdef ALU_OPERAND_STAGE_PERF_EN
    ,
    .perf_issued(perf_issued),
    .perf_stalls(perf_stalls)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [106:0] exp_q[$];

  // {alu_a, alu_b, alu_op, out_rd, out_rd_we, out_illegal, out_pc}
  function automatic logic [106:0] pack(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] op, input logic [4:0] rd,
                                        input logic we, input logic ill,
                                        input logic [31:0] pc);
    return {a, b, op, rd, we, ill, pc};
  endfunction

  logic [106:0] act_vec;
  assign act_vec = {bus.alu_a, bus.alu_b, bus.alu_op, bus.out_rd,
                    bus.out_rd_we, bus.out_illegal, bus.out_pc};

  task automatic check(input string name, input logic [106:0] act, input logic [106:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard monitor: samples mid-cycle, after all drivers have settled
  always @(negedge clk) begin
    #3;
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output: got %h with nothing queued", act_vec);
      end else begin
        logic [106:0] e;
        e = exp_q.pop_front();
        if (act_vec !== e) begin
          failures++;
          $display("FAIL scoreboard pc=%h: got a=%h b=%h op=%h rd=%0d we=%b ill=%b, expected a=%h b=%h op=%h rd=%0d we=%b ill=%b",
                   e[31:0], act_vec[106:75], act_vec[74:43], act_vec[42:39], act_vec[38:34],
                   act_vec[33], act_vec[32], e[106:75], e[74:43], e[42:39], e[38:34], e[33], e[32]);
        end
      end
    end
  end

  // driver: present one instruction, hold until accepted
  task automatic send(input logic [31:0] inst, input logic [31:0] pc,
                      input logic [31:0] r1, input logic [31:0] r2,
                      input logic fv, input logic [4:0] frd, input logic [31:0] fd,
                      input logic track, input logic [106:0] exp);
    int budget;
    @(negedge clk); #1;
    bus.in_inst = inst; bus.in_pc = pc;
    rs1_data = r1; rs2_data = r2;
    fwd_valid = fv; fwd_rd = frd; fwd_data = fd;
    bus.in_valid = 1'b1;
    #1;
    budget = 0;
    while (bus.in_ready !== 1'b1 && budget < 50) begin
      @(negedge clk); #2;
      budget++;
    end
    if (bus.in_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL send_timeout: inst %h never accepted", inst);
    end else if (track) begin
      exp_q.push_back(exp);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    fwd_valid = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d results still queued, expected 0", exp_q.size());
    end
  endtask

  localparam logic [106:0] ADDI_EXP = {32'h10, 32'hFFFFFFFF, 4'h0, 5'd5, 1'b1, 1'b0, 32'h200};

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    rs1_data = '0; rs2_data = '0; fwd_valid = 1'b0; fwd_rd = '0; fwd_data = '0;
    bus.in_valid = 1'b0; bus.in_inst = '0; bus.in_pc = '0; bus.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    check("reset_outputs", act_vec, '0);
    check("reset_valid", {106'd0, bus.out_valid}, '0);
    rst_n = 1'b1;

    // directed vectors: inst, pc, rs1_data, rs2_data, fwd_valid, fwd_rd, fwd_data
    send(32'hFFF08293, 32'h100, 32'h10, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1,
         pack(32'h10, 32'hFFFFFFFF, 4'h0, 5'd5, 1'b1, 1'b0, 32'h100));
    send(32'h405251B3, 32'h104, 32'h80000000, 32'hFFFFFF24, 1'b0, 5'd0, 32'h0, 1'b1,
         pack(32'h80000000, 32'h4, 4'hD, 5'd3, 1'b1, 1'b0, 32'h104));
    send(32'h002083B3, 32'h108, 32'h5, 32'h0, 1'b1, 5'd2, 32'hDEADBEEF, 1'b1,
         pack(32'h5, 32'hDEADBEEF, 4'h0, 5'd7, 1'b1, 1'b0, 32'h108));
    send(32'h002083B3, 32'h10C, 32'h5, 32'h0, 1'b1, 5'd0, 32'hDEADBEEF, 1'b1,
         pack(32'h5, 32'h0, 4'h0, 5'd7, 1'b1, 1'b0, 32'h10C));
    send(32'h002083B3, 32'h110, 32'h5, 32'h77, 1'b1, 5'd1, 32'hDEADBEEF, 1'b1,
         pack(32'hDEADBEEF, 32'h77, 4'h0, 5'd7, 1'b1, 1'b0, 32'h110));
    send(32'h002003B3, 32'h114, 32'h1234, 32'h9, 1'b1, 5'd0, 32'h55, 1'b1,
         pack(32'h0, 32'h9, 4'h0, 5'd7, 1'b1, 1'b0, 32'h114));
    send(32'h123450B7, 32'h118, 32'hFFFF, 32'hFFFF, 1'b0, 5'd0, 32'h0, 1'b1,
         pack(32'h0, 32'h12345000, 4'h0, 5'd1, 1'b1, 1'b0, 32'h118));
    send(32'hFFFFF117, 32'h400, 32'h1, 32'h1, 1'b0, 5'd0, 32'h0, 1'b1,
         pack(32'h400, 32'hFFFFF000, 4'h0, 5'd2, 1'b1, 1'b0, 32'h400));
    send(32'h00002083, 32'h11C, 32'h3, 32'h4, 1'b0, 5'd0, 32'h0, 1'b1,
         pack(32'h0, 32'h0, 4'h0, 5'd1, 1'b0, 1'b1, 32'h11C));
    send(32'h4020C1B3, 32'h120, 32'h3, 32'h4, 1'b0, 5'd0, 32'h0, 1'b1,
         pack(32'h0, 32'h0, 4'h0, 5'd3, 1'b0, 1'b1, 32'h120));
    send(32'h01F09313, 32'h124, 32'hABCD, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1,
         pack(32'hABCD, 32'h1F, 4'h1, 5'd6, 1'b1, 1'b0, 32'h124));
    send(32'h4030D313, 32'h128, 32'hF0000000, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1,
         pack(32'hF0000000, 32'h3, 4'hD, 5'd6, 1'b1, 1'b0, 32'h128));
    send(32'h0230D313, 32'h12C, 32'hF0000000, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1,
         pack(32'h0, 32'h0, 4'h0, 5'd6, 1'b0, 1'b1, 32'h12C));
    send(32'h8000B413, 32'h130, 32'h42, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1,
         pack(32'h42, 32'hFFFFF800, 4'h3, 5'd8, 1'b1, 1'b0, 32'h130));
    send(32'h00208033, 32'h134, 32'h1, 32'h2, 1'b0, 5'd0, 32'h0, 1'b1,
         pack(32'h1, 32'h2, 4'h0, 5'd0, 1'b0, 1'b0, 32'h134));
    send(32'h402084B3, 32'h138, 32'hA, 32'h3, 1'b0, 5'd0, 32'h0, 1'b1,
         pack(32'hA, 32'h3, 4'h8, 5'd9, 1'b1, 1'b0, 32'h138));
    send(32'h003110B3, 32'h13C, 32'h0F0F0F0F, 32'hFFFFFF21, 1'b0, 5'd0, 32'h0, 1'b1,
         pack(32'h0F0F0F0F, 32'h1, 4'h1, 5'd1, 1'b1, 1'b0, 32'h13C));
    drain();

    // backpressure: ADDI held while a LUI waits upstream
    @(negedge clk); #1;
    bus.out_ready = 1'b0;
    send(32'hFFF08293, 32'h200, 32'h10, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, ADDI_EXP);
    fork
      send(32'h123450B7, 32'h204, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1,
           pack(32'h0, 32'h12345000, 4'h0, 5'd1, 1'b1, 1'b0, 32'h204));
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk); #2;
          check("stall_in_ready", {106'd0, bus.in_ready}, '0);
          check("stall_valid", {106'd0, bus.out_valid}, 107'd1);
          check("stall_hold", act_vec, ADDI_EXP);
        end
        @(negedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // flush drops both the held instruction and the one presented alongside it
    @(negedge clk); #1;
    bus.out_ready = 1'b0;
    send(32'h402084B3, 32'h300, 32'hA, 32'h3, 1'b0, 5'd0, 32'h0, 1'b0, '0);
    @(negedge clk); #1;
    flush = 1'b1;
    bus.in_valid = 1'b1; bus.in_inst = 32'h123450B7; bus.in_pc = 32'h304;
    #1;
    check("flush_in_ready", {106'd0, bus.in_ready}, 107'd1);
    @(negedge clk); #2;
    check("flush_clears_valid", {106'd0, bus.out_valid}, '0);
    flush = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk); #2;
    check("flush_drops_input", {106'd0, bus.out_valid}, '0);

    // reset while stalled
    send(32'h002083B3, 32'h400, 32'h5, 32'h6, 1'b0, 5'd0, 32'h0, 1'b0, '0);
    @(negedge clk); #1;
    check("pre_reset_stall", {106'd0, bus.out_valid}, 107'd1);
    rst_n = 1'b0;
    @(negedge clk); #2;
    check("midreset_outputs", act_vec, '0);
    check("midreset_valid", {106'd0, bus.out_valid}, '0);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- ID/EX stage directly upstream of the 32-bit ALU.
- Decodes RV32I integer-compute instructions (OP, OP-IMM, LUI, AUIPC) and generates immediates.
- Selects and forwards operands, then registers the ALU inputs `a`, `b` and the 4-bit `op` behind a valid/ready handshake.
- The ALU consumes `alu_a`, `alu_b` and `alu_op` combinationally from this stage's output register.

Parameters:
- CNT_W, 32, width of the performance counters (used only with the optional feature).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; synchronous, active-low
- flush  input  1  synchronous pipeline flush
- in_valid  input  1  upstream instruction valid
- in_ready  output  1  stage can accept an instruction
- in_inst  input  32  instruction word
- in_pc  input  32  instruction PC
- rs1_data  input  32  register-file read data for rs1
- rs2_data  input  32  register-file read data for rs2
- fwd_valid  input  1  write-back forwarding valid
- fwd_rd  input  5  write-back destination register
- fwd_data  input  32  write-back data
- out_valid  output  1  ALU inputs valid
- out_ready  input  1  downstream accepts
- alu_a  output  32  ALU operand a
- alu_b  output  32  ALU operand b
- alu_op  output  4  ALU opcode
- out_rd  output  5  destination register
- out_rd_we  output  1  register write enable
- out_illegal  output  1  unsupported encoding
- out_pc  output  32  PC of the issued instruction

Behaviour:
- Reset (rst_n=0 at a clock edge): all outputs 0, including out_valid, alu_a, alu_b, alu_op, out_rd, out_rd_we, out_illegal and out_pc.
- Reset mid-operation discards any held instruction.
- Handshake:
  - in_ready = !out_valid | out_ready (combinational).
  - Transfer occurs when in_valid & in_ready; output register loads on the next edge, so latency is 1 cycle.
  - out_valid=1 & out_ready=0: all outputs hold stable.
  - out_ready=1 with no new input: out_valid clears.
- Flush:
  - Priority: rst_n > flush > load.
  - flush=1: out_valid cleared next edge; any input presented in that cycle is dropped.
  - in_ready=1 during flush.
- Operand source (x0 / forwarding):
  - rs1 = inst[19:15], rs2 = inst[24:20].
  - Field == 0 → operand value 0.
  - Else if fwd_valid & fwd_rd == field → fwd_data.
  - Else → rs*_data.
- ALU op codes: ADD 0000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, OR 0110, AND 0111, SUB 1000, SRA 1101.
- OP (0110011):
  - a = rs1 value, b = rs2 value.
  - funct7 0000000 with funct3 000..111 → ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND.
  - funct7 0100000 with funct3 000 → SUB; with funct3 101 → SRA.
  - For shifts, b = {27'b0, rs2[4:0]}, because the ALU shifts by the full b.
- OP-IMM (0010011):
  - a = rs1 value, b = sign-extended inst[31:20].
  - funct3 000/010/011/100/110/111 → ADD/SLT/SLTU/XOR/OR/AND.
  - funct3 001 requires inst[31:25]=0000000 → SLL.
  - funct3 101: inst[31:25]=0000000 → SRL; 0100000 → SRA.
  - For shifts, b = {27'b0, inst[24:20]}.
- LUI (0110111): a = 0, b = {inst[31:12], 12'b0}, op = ADD.
- AUIPC (0010111): a = in_pc, b = {inst[31:12], 12'b0}, op = ADD.
- out_rd and out_rd_we:
  - out_rd = inst[11:7].
  - out_rd_we = legal & (rd != 0).
- Illegal encoding (any other opcode or funct7):
  - out_illegal=1, out_rd_we=0, alu_a=alu_b=0, alu_op=0000.
  - out_valid still asserts so the trap is visible downstream.
- out_pc = in_pc, latched on transfer.

Optional Feature:
- Macro: ALU_OPERAND_STAGE_PERF_EN.
- Defined:
  - Adds outputs perf_issued[CNT_W-1:0] and perf_stalls[CNT_W-1:0], both reset to 0.
  - perf_issued increments on every transfer.
  - perf_stalls increments every cycle with out_valid & !out_ready.
  - Both counters wrap at 2^CNT_W and are not cleared by flush.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- ADDI x5,x1,-1 (0xFFF08293), rs1_data=0x10 → one cycle later out_valid=1, alu_a=0x10, alu_b=0xFFFFFFFF, alu_op=0000, out_rd=5, out_rd_we=1.
- SRA x3,x4,x5 (0x405251B3), rs1_data=0x80000000, rs2_data=0xFFFFFF24 → alu_a=0x80000000, alu_b=0x00000004, alu_op=1101.
- ADD x7,x1,x2 (0x002083B3), rs2_data=0, fwd_valid=1, fwd_rd=2, fwd_data=0xDEADBEEF → alu_b=0xDEADBEEF. Same test with fwd_rd=0 → alu_b=0.
- Backpressure: issue, then hold out_ready=0 for 3 cycles → in_ready=0 and outputs stable throughout. Then out_ready=1 with a queued LUI x1,0x12345 (0x123450B7) → next cycle alu_b=0x12345000.
- Illegal encodings, load 0x00002083 and OP funct7=0100000 funct3=100 → out_valid=1, out_illegal=1, out_rd_we=0.
- flush=1 with out_valid=1 and a simultaneous in_valid → out_valid=0 next cycle and the input is dropped. Then rst_n=0 mid-stall → all outputs 0 on the next edge.
